sram_initiator: RTL and testbench

- Initiator side of the single-ported generic SRAM interface. Converts a valid/ready request stream into SRAM `ce`/`addr`/`din`/`rnw` strobes.
- Captures read data on the only cycle it is valid, because SRAM `dout` is not retained and is scrambled afterwards.
- Returns read data in order on a valid/ready response stream.
- Sits between a client (cache or table logic) and a `generic_sram` instance.

---
 rtl/sram_initiator_pkg.sv | 15 +
 rtl/sram_rsp_fifo.sv | 60 ++++++
 rtl/sram_initiator.sv | 80 ++++++++
 tb/tb_sram_initiator.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_initiator_pkg.sv
// Shared constants and request payload type for the SRAM initiator slice.
package sram_initiator_pkg;

  localparam int WORD_W        = 32;
  localparam int WORDS_N       = 256;
  localparam int ADDR_W        = $clog2(WORDS_N);
  localparam int RSP_DEPTH_MIN = 2;

  typedef struct packed {
    logic              rnw;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// In-order flop FIFO holding captured read data until the client takes it.
module sram_rsp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_pop;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop_i & (cnt_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push_i && !do_pop) cnt_d = cnt_q + CNT_W'(1);
    else if (!push_i && do_pop) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CNT_W'(DEPTH));

endmodule

// File: rtl/sram_initiator.sv
// Request-stream to SRAM strobe converter with credit-protected in-order read return.
// Handshake: a beat transfers on a cycle where valid & ready are both high; ready never depends on valid.
module sram_initiator
  import sram_initiator_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int WORDS_N   = 256,
  parameter int RSP_DEPTH = 3,
  localparam int ADDR_W   = $clog2(WORDS_N)
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic              req_rnw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_vld,
  input  logic              rsp_rdy,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              sram_ce,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [WORD_W-1:0] sram_din,
  output logic              sram_rnw,
  input  logic [WORD_W-1:0] sram_dout
);

  localparam int DEPTH = (RSP_DEPTH < RSP_DEPTH_MIN) ? RSP_DEPTH_MIN : RSP_DEPTH;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             accept;
  logic             rd_inflight_q, rd_inflight_d;
  logic             rsp_push, rsp_pop, fifo_full;
  logic [CNT_W-1:0] rsp_cnt;
  logic [CNT_W:0]   credit_used;

  // Every accepted read owns a buffer slot from issue until it is popped.
  assign credit_used = {1'b0, rsp_cnt} + {{CNT_W{1'b0}}, rd_inflight_q};
  assign req_rdy     = ~arst & (credit_used < (CNT_W + 1)'(DEPTH));
  assign accept      = req_vld & req_rdy;

  always_comb begin
    sram_ce   = accept;
    sram_addr = '0;
    sram_din  = '0;
    sram_rnw  = 1'b0;
    if (accept) begin
      sram_addr = req_addr;
      sram_din  = req_wdata;
      sram_rnw  = req_rnw;
    end
  end

  assign rd_inflight_d = accept & req_rnw;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) rd_inflight_q <= 1'b0;
    else      rd_inflight_q <= rd_inflight_d;
  end

  // sram_dout is only meaningful the cycle after a read strobe, so capture it then.
  assign rsp_push = rd_inflight_q & ~fifo_full;
  assign rsp_vld  = (rsp_cnt != '0);
  assign rsp_pop  = rsp_vld & rsp_rdy;

  sram_rsp_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk_i       (clk),
    .arst_i      (arst),
    .push_i      (rsp_push),
    .push_data_i (sram_dout),
    .pop_i       (rsp_pop),
    .head_o      (rsp_rdata),
    .count_o     (rsp_cnt),
    .full_o      (fifo_full)
  );

endmodule

// File: tb/tb_sram_initiator.sv
// Bench for sram_initiator: behavioural SRAM, transaction-level reference model, directed and random scenarios.
module tb_sram_initiator;
  import sram_initiator_pkg::*;

  localparam int DEPTH = 3;

  logic              clk = 1'b0;
  logic              arst;
  logic              req_vld, req_rdy, req_rnw;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              rsp_vld, rsp_rdy;
  logic [WORD_W-1:0] rsp_rdata;
  logic              sram_ce, sram_rnw;
  logic [ADDR_W-1:0] sram_addr;
  logic [WORD_W-1:0] sram_din;
  logic [WORD_W-1:0] sram_dout = '0;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Behavioural SRAM: dout valid only the cycle after a read strobe, garbage otherwise.
  logic [WORD_W-1:0] sram_mem [WORDS_N];

  // Reference model: shadow memory updated at acceptance, and outstanding reads with their due cycle.
  logic [WORD_W-1:0] shadow [WORDS_N];
  logic [WORD_W-1:0] exp_q[$];
  int                due_q[$];

  logic                      mon_rdy, mon_acc, mon_vld;
  logic [2+ADDR_W+WORD_W-1:0] mon_strobe, mon_strobe_exp;

  sram_initiator #(
    .WORD_W    (WORD_W),
    .WORDS_N   (WORDS_N),
    .RSP_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .arst      (arst),
    .req_vld   (req_vld),
    .req_rdy   (req_rdy),
    .req_rnw   (req_rnw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_vld   (rsp_vld),
    .rsp_rdy   (rsp_rdy),
    .rsp_rdata (rsp_rdata),
    .sram_ce   (sram_ce),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_rnw  (sram_rnw),
    .sram_dout (sram_dout)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    if (sram_ce && sram_rnw) sram_dout <= sram_mem[sram_addr];
    else                     sram_dout <= $urandom;
    if (sram_ce && !sram_rnw) sram_mem[sram_addr] <= sram_din;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / protocol monitor ----------------
  always @(negedge clk) begin
    if (arst) begin
      n_cmp++;
      if (req_rdy !== 1'b0 || sram_ce !== 1'b0 || rsp_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL mon_reset: rdy=%b ce=%b vld=%b required 0 0 0", req_rdy, sram_ce, rsp_vld);
      end
      exp_q.delete();
      due_q.delete();
    end else begin
      mon_rdy = (exp_q.size() < DEPTH);
      n_cmp++;
      if (req_rdy !== mon_rdy) begin
        n_fail++;
        $display("FAIL mon_credit: req_rdy=%b required %b (outstanding %0d)", req_rdy, mon_rdy, exp_q.size());
      end
      mon_acc        = req_vld && mon_rdy;
      mon_strobe     = {sram_ce, sram_rnw, sram_addr, sram_din};
      mon_strobe_exp = mon_acc ? {1'b1, req_rnw, req_addr, req_wdata} : '0;
      n_cmp++;
      if (mon_strobe !== mon_strobe_exp) begin
        n_fail++;
        $display("FAIL mon_strobe: ce/rnw/addr/din=%h required %h", mon_strobe, mon_strobe_exp);
      end
      mon_vld = (exp_q.size() > 0) && (due_q[0] <= cyc);
      n_cmp++;
      if (rsp_vld !== mon_vld) begin
        n_fail++;
        $display("FAIL mon_rsp_vld: rsp_vld=%b required %b", rsp_vld, mon_vld);
      end
      if (mon_vld) begin
        n_cmp++;
        if (rsp_rdata !== exp_q[0]) begin
          n_fail++;
          $display("FAIL mon_rsp_data: rsp_rdata=%h required %h", rsp_rdata, exp_q[0]);
        end
        if (rsp_rdy) begin
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
      end
      if (mon_acc) begin
        if (req_rnw) begin
          exp_q.push_back(shadow[req_addr]);
          due_q.push_back(cyc + 2);
        end else begin
          shadow[req_addr] = req_wdata;
        end
      end
      n_cmp++;
      if (dut.rd_inflight_q && dut.fifo_full) begin
        n_fail++;
        $display("FAIL mon_overflow: push while full=1 required 0");
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input sram_req_t rq);
    req_vld   = 1'b1;
    req_rnw   = rq.rnw;
    req_addr  = rq.addr;
    req_wdata = rq.wdata;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
    logic ok;
    ok = 1'b0;
    drive_req('{rnw: 1'b0, addr: a, wdata: d});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_rdy) begin
        ok = 1'b1;
        break;
      end
      next_cycle();
    end
    next_cycle();
    req_vld = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL write_accept: accepted=%b required 1 within 20 cycles", ok);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    arst = 1'b1; rsp_rdy = 1'b0;
    drive_req('{rnw: 1'b1, addr: 8'h05, wdata: '0});
    repeat (3) next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({req_rdy, sram_ce, rsp_vld} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_hold: rdy/ce/vld=%b required 000", {req_rdy, sram_ce, rsp_vld});
    end
    next_cycle();
    arst = 1'b0; req_vld = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({req_rdy, rsp_vld} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release: rdy/vld=%b required 10", {req_rdy, rsp_vld});
    end
    next_cycle();
  endtask

  task automatic test_write_read();
    rsp_rdy = 1'b1;
    drive_req('{rnw: 1'b0, addr: 8'h10, wdata: 32'hDEADBEEF});
    @(negedge clk);
    n_cmp++;
    if ({sram_ce, sram_rnw} !== 2'b10) begin
      n_fail++;
      $display("FAIL wr_strobe: ce/rnw=%b required 10", {sram_ce, sram_rnw});
    end
    next_cycle();
    drive_req('{rnw: 1'b1, addr: 8'h10, wdata: '0});
    @(negedge clk);
    n_cmp++;
    if ({sram_ce, sram_rnw} !== 2'b11) begin
      n_fail++;
      $display("FAIL rd_strobe: ce/rnw=%b required 11", {sram_ce, sram_rnw});
    end
    next_cycle();
    req_vld = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rsp_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_latency_early: rsp_vld=%b required 0 at T+1", rsp_vld);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (rsp_vld !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL rd_data: vld=%b data=%h required 1 deadbeef", rsp_vld, rsp_rdata);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    rsp_rdy = 1'b1;
    for (int a = 0; a < 8; a++) do_write(ADDR_W'(a), WORD_W'(a * 3));
    next_cycle();
    for (int k = 0; k < 10; k++) begin
      if (k < 8) drive_req('{rnw: 1'b1, addr: ADDR_W'(k), wdata: '0});
      else       req_vld = 1'b0;
      @(negedge clk);
      if (k < 8) begin
        n_cmp++;
        if (req_rdy !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_rdy[%0d]: req_rdy=%b required 1", k, req_rdy);
        end
      end
      if (k >= 2) begin
        n_cmp++;
        if (rsp_vld !== 1'b1 || rsp_rdata !== WORD_W'((k - 2) * 3)) begin
          n_fail++;
          $display("FAIL b2b_rsp[%0d]: vld=%b data=%h required 1 %h", k, rsp_vld, rsp_rdata, WORD_W'((k - 2) * 3));
        end
      end
      next_cycle();
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drained: rsp_vld=%b required 0", rsp_vld);
    end
    next_cycle();
  endtask

  task automatic test_backpressure();
    logic [WORD_W-1:0] v [3];
    int acc;
    rsp_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v[i] = $urandom;
      do_write(ADDR_W'(8'h40 + i), v[i]);
    end
    next_cycle();
    rsp_rdy = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      drive_req('{rnw: 1'b1, addr: ADDR_W'(8'h40 + acc), wdata: '0});
      @(negedge clk);
      if (req_vld && req_rdy) acc++;
      if (c >= 2) begin
        n_cmp++;
        if (rsp_vld !== 1'b1 || rsp_rdata !== v[0]) begin
          n_fail++;
          $display("FAIL bp_stable[%0d]: vld=%b data=%h required 1 %h", c, rsp_vld, rsp_rdata, v[0]);
        end
      end
      next_cycle();
    end
    @(negedge clk);
    n_cmp++;
    if (acc !== 3 || req_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accepts: accepted=%0d rdy=%b required 3 0", acc, req_rdy);
    end
    next_cycle();
    drive_req('{rnw: 1'b0, addr: 8'h41, wdata: ~v[1]});
    @(negedge clk);
    n_cmp++;
    if (sram_ce !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_write_blocked: sram_ce=%b required 0", sram_ce);
    end
    next_cycle();
    req_vld = 1'b0;
    rsp_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_vld !== 1'b1 || rsp_rdata !== v[i]) begin
        n_fail++;
        $display("FAIL bp_drain[%0d]: vld=%b data=%h required 1 %h", i, rsp_vld, rsp_rdata, v[i]);
      end
      if (i == 1) begin
        n_cmp++;
        if (req_rdy !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_credit_return: req_rdy=%b required 1", req_rdy);
        end
      end
      next_cycle();
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_empty: rsp_vld=%b required 0", rsp_vld);
    end
    next_cycle();
  endtask

  task automatic test_read_write_hazard();
    rsp_rdy = 1'b1;
    do_write(8'h20, 32'h11);
    next_cycle();
    drive_req('{rnw: 1'b1, addr: 8'h20, wdata: '0});
    next_cycle();
    drive_req('{rnw: 1'b0, addr: 8'h20, wdata: 32'h22});
    @(negedge clk);
    n_cmp++;
    if ({sram_ce, sram_rnw} !== 2'b10) begin
      n_fail++;
      $display("FAIL hz_write_strobe: ce/rnw=%b required 10", {sram_ce, sram_rnw});
    end
    next_cycle();
    req_vld = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rsp_vld !== 1'b1 || rsp_rdata !== 32'h11) begin
      n_fail++;
      $display("FAIL hz_old_data: vld=%b data=%h required 1 00000011", rsp_vld, rsp_rdata);
    end
    next_cycle();
    drive_req('{rnw: 1'b1, addr: 8'h20, wdata: '0});
    next_cycle();
    req_vld = 1'b0;
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (rsp_vld !== 1'b1 || rsp_rdata !== 32'h22) begin
      n_fail++;
      $display("FAIL hz_new_data: vld=%b data=%h required 1 00000022", rsp_vld, rsp_rdata);
    end
    next_cycle();
  endtask

  task automatic test_reset_midop();
    rsp_rdy = 1'b1;
    drive_req('{rnw: 1'b1, addr: 8'h03, wdata: '0});
    @(negedge clk);
    n_cmp++;
    if (sram_ce !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_issue: sram_ce=%b required 1", sram_ce);
    end
    next_cycle();
    req_vld = 1'b0;
    arst    = 1'b1;
    repeat (2) next_cycle();
    arst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_vld !== 1'b0 || req_rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL midrst_quiet[%0d]: vld=%b rdy=%b required 0 1", i, rsp_vld, req_rdy);
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    sram_req_t rq;
    logic      last_rdy;
    last_rdy = 1'b1;
    req_vld  = 1'b0;
    for (int i = 0; i < 400; i++) begin
      // Payload held while a request waits for credit.
      if (!(req_vld && !last_rdy)) begin
        rq.rnw   = $urandom_range(0, 1);
        rq.addr  = ADDR_W'($urandom_range(0, 7));
        rq.wdata = $urandom;
        drive_req(rq);
        req_vld = ($urandom_range(0, 3) != 0);
      end
      rsp_rdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      last_rdy = req_rdy;
      next_cycle();
    end
    req_vld = 1'b0;
    rsp_rdy = 1'b1;
    repeat (8) next_cycle();
    @(negedge clk);
    n_cmp++;
    if (rsp_vld !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_drain: vld=%b outstanding=%0d required 0 0", rsp_vld, exp_q.size());
    end
    next_cycle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    arst = 1'b1; req_vld = 1'b0; req_rnw = 1'b0; req_addr = '0; req_wdata = '0; rsp_rdy = 1'b0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_read_write_hazard();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
